// File: rtl/crc24.sv
// Byte-parallel CRC-24 (default LTE gCRC24A), MSB first, zero init, no reflection or final XOR.
// Optional CRC24_VALID_EN adds a crc_valid flag that rises after the last compute cycle.
module crc24 #(
    parameter logic [23:0] POLY = 24'h864CFB
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en_com,
    input  logic [7:0]  d_in,
    output logic [23:0] crc_out
`ifdef CRC24_VALID_EN
    ,
    output logic        crc_valid
`endif
);

    logic [7:0]  byte_q;
    logic [23:0] crc_q;

    // Eight serial LFSR steps unrolled into one cycle, bit 7 first.
    function automatic logic [23:0] crc_byte(input logic [23:0] c, input logic [7:0] b);
        logic [23:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[23] ^ b[i];
            r  = {r[22:0], 1'b0} ^ (fb ? POLY : 24'h000000);
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_q <= 8'h00;
        end else begin
            byte_q <= d_in;
        end
    end

    // The byte folded here is the one captured on the previous edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= 24'h000000;
        end else if (init) begin
            crc_q <= 24'h000000;
        end else if (en_com) begin
            crc_q <= crc_byte(crc_q, byte_q);
        end
    end

    assign crc_out = crc_q;

`ifdef CRC24_VALID_EN
    logic en_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q      <= 1'b0;
            crc_valid <= 1'b0;
        end else begin
            en_q <= en_com;
            if (init || en_com) begin
                crc_valid <= 1'b0;
            end else if (en_q) begin
                crc_valid <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_crc24.sv
// Directed bench for crc24: reset, single bytes, gating, init priority, long message and residue.
module tb_crc24;

    logic        clk = 1'b0;
    logic        reset, init, en_com;
    logic [7:0]  d_in;
    logic [23:0] crc_out;
`ifdef CRC24_VALID_EN
    logic        crc_valid;
`endif

    int n_chk = 0;
    int n_bad = 0;

    logic [7:0]  msg [0:131];
    logic [23:0] m;

    always #5 clk = ~clk;

    crc24 dut (
        .clk     (clk),
        .reset   (reset),
        .init    (init),
        .en_com  (en_com),
        .d_in    (d_in),
        .crc_out (crc_out)
`ifdef CRC24_VALID_EN
        ,
        .crc_valid (crc_valid)
`endif
    );

    task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %06h want %06h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Serial bit-at-a-time reference over msg[0:len-1].
    function automatic logic [23:0] model(input int len);
        logic [23:0] c;
        logic        fb;
        c = 24'h000000;
        for (int k = 0; k < len; k++) begin
            for (int i = 7; i >= 0; i--) begin
                fb = c[23] ^ msg[k][i];
                c  = {c[22:0], 1'b0};
                if (fb) c = c ^ 24'h864CFB;
            end
        end
        return c;
    endfunction

    task automatic stream(input int len);
        init = 1'b1; en_com = 1'b0; d_in = msg[0];
        cyc();
        init = 1'b0;
        for (int k = 1; k < len; k++) begin
            en_com = 1'b1; d_in = msg[k];
            cyc();
        end
        en_com = 1'b1; d_in = 8'h00;
        cyc();
        en_com = 1'b0;
    endtask

    initial begin
        reset = 1'b1; init = 1'b1; en_com = 1'b1; d_in = 8'hA5;
        cyc();
        chk("rst1", crc_out, 24'h000000);
        init = 1'b0;
        cyc();
        chk("rst2", crc_out, 24'h000000);
        reset = 1'b0; en_com = 1'b0;

        // single byte 0x01
        init = 1'b1; d_in = 8'h01;
        cyc();
        chk("init0", crc_out, 24'h000000);
        init = 1'b0; en_com = 1'b1; d_in = 8'h00;
        cyc();
        chk("b01", crc_out, 24'h864CFB);
        en_com = 1'b0;
        cyc();
        chk("hold", crc_out, 24'h864CFB);

        // single byte 0x02
        init = 1'b1; d_in = 8'h02;
        cyc();
        init = 1'b0; en_com = 1'b1; d_in = 8'h00;
        cyc();
        chk("b02", crc_out, 24'h8AD50D);
        en_com = 1'b0;

        // enable gating
        init = 1'b1; d_in = 8'h01;
        cyc();
        init = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("gate0", crc_out, 24'h000000);
        end
        en_com = 1'b1;
        cyc();
        chk("gate1", crc_out, 24'h864CFB);
        en_com = 1'b0;

        // init beats en_com with 0xFF captured
        d_in = 8'hFF;
        cyc();
        init = 1'b1; en_com = 1'b1;
        cyc();
        chk("prio", crc_out, 24'h000000);
        init = 1'b0; en_com = 1'b0; d_in = 8'h00;
        cyc();

        // long message
        for (int k = 0; k < 129; k++) msg[k] = 8'((k * 37 + 11) ^ (k >> 2));
        m = model(129);
        stream(129);
        chk("long", crc_out, m);

        // appending the CRC leaves zero residue
        msg[129] = m[23:16]; msg[130] = m[15:8]; msg[131] = m[7:0];
        stream(132);
        chk("resid", crc_out, 24'h000000);

        // reset mid-message clears both CRC and byte register
        init = 1'b1; en_com = 1'b0; d_in = 8'h5A;
        cyc();
        init = 1'b0; en_com = 1'b1; d_in = 8'h3C;
        cyc();
        msg[0] = 8'h5A;
        chk("part", crc_out, model(1));
        reset = 1'b1; d_in = 8'h77;
        cyc();
        chk("rstmid", crc_out, 24'h000000);
        reset = 1'b0; en_com = 1'b1; d_in = 8'h00;
        cyc();
        chk("rstbyte", crc_out, 24'h000000);
        en_com = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/crc24.md
CRC24 -- requirements
Module: crc24

Interface
REQ-001 SHALL have parameter POLY, default 24'h864CFB, meaning generator polynomial without the x^24 term (LTE gCRC24A).
REQ-002 SHALL have port clk  input  1  rising-edge clock; sole clock domain.
REQ-003 SHALL have port reset  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port init  input  1  synchronous clear of the CRC state at the start of a new message.
REQ-005 SHALL have port en_com  input  1  compute enable; folds the previously captured byte into the CRC.
REQ-006 SHALL have port d_in  input  8  message byte; bit 7 is the first bit in transmission order.
REQ-007 SHALL have port crc_out  output  24  current CRC register; bit 23 is the first CRC bit transmitted.

Function
REQ-008 SHALL capture d_in into an internal 8-bit byte register on every rising edge, independent of en_com and init.
REQ-009 SHALL, when en_com=1 and init=0, update the CRC from the byte register (the byte captured on the previous edge), giving a one-cycle input pipeline.
REQ-010 SHALL process all 8 byte bits in one cycle, MSB first; per bit: fb = crc[23] ^ bit; crc = {crc[22:0],1'b0} ^ (fb ? POLY : 0).
REQ-011 SHALL hold the CRC register unchanged when en_com=0 and init=0.
REQ-012 SHALL clear the CRC register to 24'h000000 when init=1, taking priority over en_com in the same cycle.
REQ-013 SHALL drive crc_out directly from the CRC register, reflecting an update on the edge after the enable cycle, with no combinational path from d_in or en_com.
REQ-014 SHALL support back-to-back bytes with en_com held high, one byte per cycle, unlimited message length.
REQ-015 SHALL produce, for the final data byte presented on cycle N, a final CRC on crc_out after the edge at cycle N+1, provided en_com=1 on cycle N+1.
REQ-016 SHALL treat the POLY value as the only width-24 arithmetic; no reflection, no final XOR, and an initial value of 0.

Reset
REQ-017 SHALL, when reset=1 at a rising edge, set the CRC register to 0 and the byte register to 0; reset overrides init and en_com.
REQ-018 SHALL resume normal operation on the first edge with reset=0; a reset mid-message discards the partial CRC.

Configuration
REQ-019 SHALL, when macro CRC24_VALID_EN is defined, add output crc_valid (1 bit, reset 0), which is set to 1 on the edge after the last en_com=1 cycle (en_com falling) and cleared by init, reset, or en_com=1.
REQ-020 SHALL, without CRC24_VALID_EN, have no crc_valid port, with all other behaviour identical.

Verification
REQ-021 SHALL verify reset: reset=1 for 2 cycles with arbitrary init, en_com and d_in -> crc_out=24'h000000.
REQ-022 SHALL verify a single byte: init pulse, byte 0x01, then en_com=1 for one cycle -> crc_out=24'h864CFB.
REQ-023 SHALL verify a second single-byte case: init pulse, byte 0x02, en_com one cycle -> crc_out=24'h8AD50D.
REQ-024 SHALL verify enable gating: byte 0x01 captured with en_com=0 for 5 cycles -> crc_out stays 24'h000000; then en_com=1 for one cycle -> crc_out=24'h864CFB.
REQ-025 SHALL verify priority: init=1 and en_com=1 in the same cycle with byte 0xFF -> crc_out=24'h000000.
REQ-026 SHALL verify a long message: init, then 129 bytes streamed with en_com=1 and an extra en_com=1 flush cycle -> crc_out equals the bitwise software model of REQ-010, and appending those 3 CRC bytes MSB first yields a CRC of 0.
